arrow_cmd_queue: RTL and testbench

- Input conditioner between the four raw arrow buttons and the snake game-step logic.
- Synchronises and debounces each button, then turns presses into direction commands.
- Filters reversals and duplicates, and buffers accepted commands in a small FIFO.
- Releases exactly one command per game tick, and supplies a press-entropy random seed for apple placement.

---
 rtl/arrow_cmd_queue.sv | 158 +++++++++++++++
 tb/tb_arrow_cmd_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arrow_cmd_queue.sv
// arrow_cmd_queue: turns four raw arrow buttons into filtered direction
// commands, queues them, and releases one per game tick. Also keeps a
// free-running LFSR that is stirred by accepted presses to seed apple placement.
module arrow_cmd_queue #(
  parameter int         DEBOUNCE_CYCLES = 200000,
  parameter int         FIFO_DEPTH      = 2,
  parameter logic [3:0] ACTIVE_LOW_MASK = 4'b0011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arrow_up,
  input  logic        arrow_down,
  input  logic        arrow_left,
  input  logic        arrow_right,
  input  logic        tick,
  output logic [1:0]  dir,
  output logic        step_valid,
  output logic [2:0]  queue_count,
  output logic        cmd_dropped,
  output logic [15:0] seed
);

  localparam int          CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]  DEPTH     = 3'(FIFO_DEPTH);
  localparam logic [15:0] SEED_INIT = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // button bit order {right,left,down,up}; bit 0 has the highest priority
  logic [3:0]    raw, sync1, sync2, level, deb, press, pending, serve;
  logic [CW-1:0] db_cnt [4];
  logic [1:0]    cand, tail_dir, ref_dir;
  logic          cand_valid, filter_ok, pop, space, push, drop;
  logic [1:0]    q      [FIFO_DEPTH];
  logic [1:0]    q_next [FIFO_DEPTH];
  logic [2:0]    wr_idx;
  logic [15:0]   cyc_cnt, lfsr_adv, mixed, seed_next;

  assign raw   = {arrow_right, arrow_left, arrow_down, arrow_up};
  assign level = sync2 ^ ACTIVE_LOW_MASK;

  // two-flop synchroniser, parked at the released level in reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= ACTIVE_LOW_MASK;
      sync2 <= ACTIVE_LOW_MASK;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // per-button debounce: count cycles of disagreement, flip on the last one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (level[i] != deb[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            deb[i]    <= level[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // press event = debounced state flipping from released to pressed this cycle
  always_comb begin
    press = '0;
    for (int i = 0; i < 4; i++)
      press[i] = level[i] & ~deb[i] & (db_cnt[i] == DB_LAST);
  end

  // serve the highest-priority pending button as this cycle's candidate
  always_comb begin
    serve      = '0;
    cand       = '0;
    cand_valid = |pending;
    if (pending[0])      begin serve = 4'b0001; cand = 2'd0; end
    else if (pending[1]) begin serve = 4'b0010; cand = 2'd1; end
    else if (pending[2]) begin serve = 4'b0100; cand = 2'd2; end
    else if (pending[3]) begin serve = 4'b1000; cand = 2'd3; end
  end

  // pending bits: clear the served one, set new presses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~serve) | press;
  end

  // reversal/duplicate filter against the newest queued or current direction
  always_comb begin
    tail_dir = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (queue_count == 3'(i + 1)) tail_dir = q[i];
    ref_dir   = (queue_count != 3'd0) ? tail_dir : dir;
    filter_ok = cand_valid && (cand != ref_dir) && (cand != (ref_dir ^ 2'b01));
    pop       = tick && (queue_count != 3'd0);
    space     = (queue_count < DEPTH) || pop;
    push      = filter_ok && space;
    drop      = filter_ok && !space;
    wr_idx    = pop ? queue_count - 3'd1 : queue_count;
  end

  // shift-register FIFO: entry 0 is the head, pushes land just past the tail
  always_comb begin
    q_next = q;
    if (pop)
      for (int i = 0; i < FIFO_DEPTH - 1; i++) q_next[i] = q[i + 1];
    if (push)
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (wr_idx == 3'(i)) q_next[i] = cand;
  end

  // queue storage, occupancy and per-tick outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) q[i] <= '0;
      queue_count <= '0;
      dir         <= '0;
      step_valid  <= 1'b0;
      cmd_dropped <= 1'b0;
    end else begin
      q           <= q_next;
      step_valid  <= tick;
      cmd_dropped <= drop;
      if (pop) dir <= q[0];
      if (push && !pop)      queue_count <= queue_count + 3'd1;
      else if (pop && !push) queue_count <= queue_count - 3'd1;
    end
  end

  // Galois LFSR step, stirred with the cycle count on each accepted push
  always_comb begin
    lfsr_adv  = {1'b0, seed[15:1]} ^ (seed[0] ? LFSR_TAPS : 16'h0000);
    mixed     = push ? (lfsr_adv ^ cyc_cnt) : lfsr_adv;
    seed_next = (mixed == 16'h0000) ? SEED_INIT : mixed;
  end

  // seed register and free-running cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seed    <= SEED_INIT;
      cyc_cnt <= '0;
    end else begin
      seed    <= seed_next;
      cyc_cnt <= cyc_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_arrow_cmd_queue.sv
// tb_arrow_cmd_queue: directed scenarios plus random button/tick traffic,
// every cycle compared against a queue-based behavioural model.
module tb_arrow_cmd_queue;

  localparam int         DB    = 4;
  localparam int         DEPTH = 2;
  localparam logic [3:0] ALM   = 4'b0011;

  logic        clk, reset;
  logic        arrow_up, arrow_down, arrow_left, arrow_right, tick;
  logic [1:0]  dir;
  logic        step_valid, cmd_dropped;
  logic [2:0]  queue_count;
  logic [15:0] seed;

  arrow_cmd_queue #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(DEPTH), .ACTIVE_LOW_MASK(ALM)) dut (
    .clk(clk), .reset(reset),
    .arrow_up(arrow_up), .arrow_down(arrow_down),
    .arrow_left(arrow_left), .arrow_right(arrow_right),
    .tick(tick), .dir(dir), .step_valid(step_valid),
    .queue_count(queue_count), .cmd_dropped(cmd_dropped), .seed(seed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // bench-side view of which buttons are physically held (1 = pressed)
  logic [3:0] pressed;

  // model state
  logic [3:0]  m_s1, m_s2, m_deb, m_pend;
  int          m_run [4];
  int          m_fifo [$];
  int          m_dir;
  int          m_sv, m_drop;
  logic [15:0] m_seed, m_cyc;
  int          opposite [4] = '{1, 0, 3, 2};

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_pend = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_fifo.delete();
    m_dir = 0; m_sv = 0; m_drop = 0;
    m_seed = 16'hACE1; m_cyc = 16'h0000;
  endtask

  task automatic model_step(input int t);
    logic [3:0]  newp;
    logic [15:0] nxt;
    int cand, rd, sz;
    bit ok, pop, push, room;
    newp = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_deb[i] = m_s2[i];
          m_run[i] = 0;
          if (m_s2[i]) newp[i] = 1'b1;
        end
      end else m_run[i] = 0;
    end
    cand = -1;
    for (int i = 0; i < 4; i++)
      if (cand < 0 && m_pend[i]) begin cand = i; m_pend[i] = 1'b0; end
    sz   = m_fifo.size();
    rd   = (sz > 0) ? m_fifo[sz-1] : m_dir;
    ok   = (cand >= 0) && (cand != rd) && (cand != opposite[rd]);
    pop  = (t != 0) && (sz > 0);
    room = (sz < DEPTH) || pop;
    push = ok && room;
    nxt  = (m_seed & 16'h1) ? ((m_seed >> 1) ^ 16'hB400) : (m_seed >> 1);
    if (push) nxt = nxt ^ m_cyc;
    if (nxt == 16'h0000) nxt = 16'hACE1;
    m_seed = nxt;
    m_cyc  = m_cyc + 16'd1;
    if (pop)  m_dir = m_fifo.pop_front();
    if (push) m_fifo.push_back(cand);
    m_sv   = t;
    m_drop = (ok && !room) ? 1 : 0;
    m_pend = m_pend | newp;
    m_s2   = m_s1;
    m_s1   = pressed;
  endtask

  task automatic compare_all();
    check_eq("dir", dir, m_dir);
    check_eq("step_valid", step_valid, m_sv);
    check_eq("queue_count", queue_count, m_fifo.size());
    check_eq("cmd_dropped", cmd_dropped, m_drop);
    check_eq("seed", seed, m_seed);
  endtask

  task automatic cycle(input int t);
    @(negedge clk);
    tick = (t != 0);
    {arrow_right, arrow_left, arrow_down, arrow_up} = pressed ^ ALM;
    @(posedge clk);
    model_step(t);
    #1;
    compare_all();
  endtask

  task automatic check_reset_values();
    check_eq("rst_dir", dir, 0);
    check_eq("rst_step_valid", step_valid, 0);
    check_eq("rst_queue_count", queue_count, 0);
    check_eq("rst_cmd_dropped", cmd_dropped, 0);
    check_eq("rst_seed", seed, 16'hACE1);
  endtask

  // reset asserted between edges; outputs must clear without waiting for clk
  task automatic apply_reset();
    @(posedge clk);
    #2;
    tick  = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic press_btn(input int b, input int hold, input int gap, output int drops);
    drops = 0;
    pressed[b] = 1'b1;
    for (int k = 0; k < hold; k++) begin cycle(0); drops += cmd_dropped; end
    pressed[b] = 1'b0;
    for (int k = 0; k < gap; k++) begin cycle(0); drops += cmd_dropped; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, drops, d;
    reset   = 1'b0;
    tick    = 1'b0;
    pressed = '0;
    {arrow_right, arrow_left, arrow_down, arrow_up} = ALM;
    model_reset();
    apply_reset();

    // 1: tick on empty queue
    cycle(1);
    cycle(0);

    // 2: right press latency, then bounce on left
    lat = -1;
    pressed[3] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cycle(0);
      if (lat < 0 && queue_count == 3'd1) lat = k;
    end
    check_eq("press_latency_window", int'(lat >= 7 && lat <= 9), 1);
    pressed[3] = 1'b0;
    for (int k = 0; k < 10; k++) cycle(0);
    cycle(1);
    check_eq("s2_dir_right", dir, 3);
    check_eq("s2_queue_empty", queue_count, 0);
    for (int r = 0; r < 4; r++) begin
      pressed[2] = 1'b1; for (int k = 0; k < 3; k++) cycle(0);
      pressed[2] = 1'b0; for (int k = 0; k < 3; k++) cycle(0);
    end
    for (int k = 0; k < 8; k++) cycle(0);
    check_eq("s2_bounce_ignored", queue_count, 0);

    // 3: reversal and duplicate from dir=0
    apply_reset();
    press_btn(1, 10, 10, d);
    press_btn(0, 10, 10, drops);
    check_eq("s3_queue_count", queue_count, 0);
    check_eq("s3_drops", d + drops, 0);

    // 4: left, right(rejected), up fill the queue; then overflow
    press_btn(2, 10, 10, d);
    press_btn(3, 10, 10, d);
    press_btn(0, 10, 10, d);
    check_eq("s4_queue_full", queue_count, 2);
    press_btn(1, 10, 10, drops);
    check_eq("s4_reversal_no_drop", drops, 0);
    press_btn(2, 10, 10, drops);
    check_eq("s4_drop_pulses", drops, 1);
    check_eq("s4_queue_still_full", queue_count, 2);

    // 6: push lands on the same cycle as a tick while full
    drops = 0;
    pressed[3] = 1'b1;
    for (int k = 1; k <= 7; k++) begin cycle(k == 7); drops += cmd_dropped; end
    check_eq("s6_dir_old_head", dir, 2);
    check_eq("s6_queue_count", queue_count, 2);
    for (int k = 0; k < 5; k++) begin cycle(0); drops += cmd_dropped; end
    check_eq("s6_no_drop", drops, 0);
    pressed[3] = 1'b0;
    apply_reset();
    for (int k = 0; k < 10; k++) cycle(0);

    // 5: simultaneous down+left from dir=2
    press_btn(2, 10, 10, d);
    cycle(1);
    check_eq("s5_dir_left", dir, 2);
    pressed[1] = 1'b1; pressed[2] = 1'b1;
    for (int k = 0; k < 12; k++) cycle(0);
    pressed[1] = 1'b0; pressed[2] = 1'b0;
    for (int k = 0; k < 10; k++) cycle(0);
    check_eq("s5_two_queued", queue_count, 2);
    cycle(1);
    check_eq("s5_first_down", dir, 1);
    cycle(1);
    check_eq("s5_then_left", dir, 2);

    // random traffic with one reset in the middle
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) pressed[b] = ~pressed[b];
      if (n == 700) apply_reset();
      cycle($urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
